// File: rtl/reception_module_if.sv
// Bundle between the serial receiver and its neighbours: the en/sda/scl
// triple from the transmitter, the valid/ready word port to the consumer,
// and the status flags.
interface reception_module_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  en_i;
    logic                  sda_i;
    logic                  scl_i;
    logic [DATA_WIDTH-1:0] data_o;
    logic                  valid_o;
    logic                  ready_i;
    logic                  busy_o;
    logic                  frame_err_o;
    logic                  overrun_o;

    // Receiver side
    modport master (
        input  en_i, sda_i, scl_i, ready_i,
        output data_o, valid_o, busy_o, frame_err_o, overrun_o
    );

    // Transmitter/consumer side
    modport slave (
        output en_i, sda_i, scl_i, ready_i,
        input  data_o, valid_o, busy_o, frame_err_o, overrun_o
    );
endinterface

// File: rtl/reception_module.sv
// Serial receiver: synchronises the asynchronous en/sda/scl triple,
// shifts in DATA_WIDTH bits MSB first on scl rising edges and hands each
// word to a single-entry valid/ready holding register. Flags aborted
// frames, excess clocks and dropped words.
module reception_module #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input logic                clk_i,
    input logic                reset_i,
    reception_module_if.master bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  en_sync_q, en_sync_d;
    logic [SYNC_STAGES-1:0]  sda_sync_q, sda_sync_d;
    logic [SYNC_STAGES-1:0]  scl_sync_q, scl_sync_d;
    logic                    scl_q, scl_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    frame_err_q, frame_err_d;
    logic                    overrun_q, overrun_d;

    logic                    en_s, sda_s, scl_s, scl_rise;
    logic                    push;
    logic [CW-1:0]           cnt_inc;

    assign en_s     = en_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    // Saturate so excess edges can never wrap the count back into range
    assign cnt_inc  = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;

    // Synchroniser chains and the delayed scl used for edge detection
    always_comb begin
        en_sync_d  = {en_sync_q[SYNC_STAGES-2:0],  bus.en_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], bus.sda_i};
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], bus.scl_i};
        scl_d      = scl_s;
    end

    // Frame FSM: bit capture on scl_rise, abort / excess-clock detection
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (en_s) begin
                    state_d = RECV;
                    shift_d = '0;
                end
            end
            RECV: begin
                // Sample first, then judge an en fall against the new count
                if (scl_rise) begin
                    shift_d = {shift_q[DATA_WIDTH-2:0], sda_s};
                    cnt_d   = cnt_inc;
                end
                if (cnt_d == FULL) begin
                    push    = 1'b1;
                    state_d = DONE;
                end else if (!en_s) begin
                    frame_err_d = (cnt_d != '0);
                    state_d     = IDLE;
                    cnt_d       = '0;
                end
            end
            DONE: begin
                if (!en_s) begin
                    state_d = IDLE;
                end else if (scl_rise) begin
                    frame_err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-entry holding register; a push with a full, stalled slot is lost
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (push) begin
            if (!valid_q || bus.ready_i) begin
                data_d  = shift_d;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.ready_i) begin
            valid_d = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            en_sync_q   <= '0;
            sda_sync_q  <= '0;
            scl_sync_q  <= '0;
            scl_q       <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_sync_q   <= en_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_sync_q  <= scl_sync_d;
            scl_q       <= scl_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.data_o      = data_q;
    assign bus.valid_o     = valid_q;
    assign bus.busy_o      = busy_q;
    assign bus.frame_err_o = frame_err_q;
    assign bus.overrun_o   = overrun_q;
endmodule
